// File: rtl/serial_parallel_rx_pkg.sv
// Shared definitions for the serial receive path: the idle comma, the
// byte type shared with the transmitter, and the receiver alignment states.
package sp_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t COMMA = 8'hBC;

  typedef enum logic [1:0] {
    SEARCH,
    SYNC,
    ACTIVE
  } rx_state_t;

endpackage

// File: rtl/serial_parallel_rx_if.sv
// Serial-in / framed-byte-out bundle between the bit stream source and the receiver.
interface serial_parallel_rx_if;
  import sp_pkg::*;

  logic  data_in;
  byte_t data_out;
  logic  valid_out;
  logic  byte_strobe;
  logic  active;

  // master feeds the serial bits and consumes the framed bytes; slave is the receiver
  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  byte_strobe,
    input  active
  );

  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output byte_strobe,
    output active
  );

endinterface

// File: rtl/serial_parallel_rx_comma_detector.sv
// Serial shift register plus idle-comma compare; exposes the byte that
// includes the bit arriving this cycle so decisions are made on the same edge.
module comma_detector
  import sp_pkg::*;
(
  input  logic  clk_8f,
  input  logic  reset,
  input  logic  data_in,
  output byte_t nxt,
  output logic  match
);

  // Only seven history bits are needed; the eighth comes straight from data_in.
  logic [6:0] sr;

  assign nxt   = {sr, data_in};
  assign match = (nxt == COMMA);

  always_ff @(posedge clk_8f) begin
    if (reset) begin
      sr <= '0;
    end else begin
      sr <= nxt[6:0];
    end
  end

endmodule

// File: rtl/serial_parallel_rx.sv
// Serial-to-parallel receiver: locks byte alignment on idle commas and delivers
// data bytes with a valid flag. Define RX_REALIGN_EN to allow relock from ACTIVE.
module serial_parallel_rx
  import sp_pkg::*;
#(
  parameter int COMMA_COUNT = 4
) (
  input  logic                 clk_8f,
  input  logic                 reset,
  serial_parallel_rx_if.slave  bus
);

  localparam logic [3:0] COMMA_TARGET = 4'(COMMA_COUNT);

  rx_state_t  state;
  logic [2:0] bc;
  logic [3:0] ccnt;
  logic [3:0] ccnt_inc;
  logic       boundary;
  byte_t      nxt;
  logic       match;
  byte_t      data_q;
  logic       valid_q;
  logic       strobe_q;
  logic       active_q;
`ifdef RX_REALIGN_EN
  logic       last_comma;
`endif

  comma_detector u_comma_detector (
    .clk_8f  (clk_8f),
    .reset   (reset),
    .data_in (bus.data_in),
    .nxt     (nxt),
    .match   (match)
  );

  assign boundary = (bc == 3'd7);
  assign ccnt_inc = ccnt + 4'd1;

  // Forcing bc to 0 on a lock makes the next boundary land 8 cycles later.
  always_ff @(posedge clk_8f) begin
    if (reset) begin
      state      <= SEARCH;
      bc         <= '0;
      ccnt       <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      strobe_q   <= 1'b0;
      active_q   <= 1'b0;
`ifdef RX_REALIGN_EN
      last_comma <= 1'b0;
`endif
    end else begin
      strobe_q <= 1'b0;
      bc       <= bc + 3'd1;
      unique case (state)
        SEARCH: begin
          if (match) begin
            bc   <= '0;
            ccnt <= 4'd1;
            if (COMMA_COUNT == 1) begin
              state      <= ACTIVE;
              active_q   <= 1'b1;
`ifdef RX_REALIGN_EN
              last_comma <= 1'b1;
`endif
            end else begin
              state <= SYNC;
            end
          end
        end
        SYNC: begin
          if (boundary) begin
            if (match) begin
              ccnt <= ccnt_inc;
              if (ccnt_inc >= COMMA_TARGET) begin
                state      <= ACTIVE;
                active_q   <= 1'b1;
`ifdef RX_REALIGN_EN
                last_comma <= 1'b1;
`endif
              end
            end else begin
              state <= SEARCH;
              ccnt  <= '0;
            end
          end
        end
        ACTIVE: begin
          if (boundary) begin
            strobe_q <= 1'b1;
            if (match) begin
              valid_q <= 1'b0;
            end else begin
              data_q  <= nxt;
              valid_q <= 1'b1;
            end
`ifdef RX_REALIGN_EN
            last_comma <= match;
          end else if (match && last_comma) begin
            bc       <= '0;
            ccnt     <= 4'd1;
            state    <= SYNC;
            active_q <= 1'b0;
            valid_q  <= 1'b0;
`endif
          end
        end
        default: begin
          state <= SEARCH;
        end
      endcase
    end
  end

  assign bus.data_out    = data_q;
  assign bus.valid_out   = valid_q;
  assign bus.byte_strobe = strobe_q;
  assign bus.active      = active_q;

endmodule

// File: tb/tb_serial_parallel_rx.sv
// Bench for serial_parallel_rx: directed byte streams checked every cycle against
// a time-indexed protocol model, plus hand-computed literal expectations.
module tb_serial_parallel_rx;
  import sp_pkg::*;

  localparam int CC = 4;

  logic clk_8f = 1'b0;
  logic reset  = 1'b1;

  serial_parallel_rx_if bus ();

  serial_parallel_rx #(.COMMA_COUNT(CC)) dut (
    .clk_8f (clk_8f),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_8f = ~clk_8f;

  int vectors     = 0;
  int miscompares = 0;
  bit checking    = 1'b0;

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0b, expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // Protocol model: keeps every bit since reset and derives byte boundaries
  // from the absolute bit index of the last lock, not from a wrapping counter.
  bit         hist[$];
  int         n;
  int         lock_n;
  int         commas;
  int         m_mode;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_strobe;
  logic       m_active;
  logic       m_last;
  logic [7:0] win;
  bit         is_comma;
  bit         at_boundary;

  always @(posedge clk_8f) begin
    if (reset) begin
      hist.delete();
      n        = 0;
      lock_n   = 0;
      commas   = 0;
      m_mode   = 0;
      m_data   = 8'h00;
      m_valid  = 1'b0;
      m_strobe = 1'b0;
      m_active = 1'b0;
      m_last   = 1'b0;
    end else begin
      hist.push_back(bus.data_in);
      n++;
      win = 8'h00;
      for (int i = 0; i < 8; i++) begin
        if (n - 1 - i >= 0) win[i] = hist[n - 1 - i];
      end
      is_comma    = (win == COMMA);
      at_boundary = (m_mode != 0) && (n > lock_n) && (((n - lock_n) % 8) == 0);
      m_strobe    = 1'b0;
      if (m_mode == 0) begin
        if (is_comma) begin
          lock_n = n;
          commas = 1;
          m_mode = (CC == 1) ? 2 : 1;
          m_last = 1'b1;
        end
      end else if (m_mode == 1) begin
        if (at_boundary) begin
          if (is_comma) begin
            commas++;
            if (commas >= CC) begin
              m_mode = 2;
              m_last = 1'b1;
            end
          end else begin
            m_mode = 0;
            commas = 0;
          end
        end
      end else begin
        if (at_boundary) begin
          m_strobe = 1'b1;
          if (is_comma) begin
            m_valid = 1'b0;
          end else begin
            m_data  = win;
            m_valid = 1'b1;
          end
          m_last = is_comma;
        end
`ifdef RX_REALIGN_EN
        else if (is_comma && m_last) begin
          lock_n  = n;
          commas  = 1;
          m_mode  = 1;
          m_valid = 1'b0;
        end
`endif
      end
      m_active = (m_mode == 2);
    end
  end

  always @(negedge clk_8f) begin
    if (checking) begin
      check_output("data_out", bus.data_out, m_data);
      check_bit("valid_out", bus.valid_out, m_valid);
      check_bit("byte_strobe", bus.byte_strobe, m_strobe);
      check_bit("active", bus.active, m_active);
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk_8f);
    reset       = 1'b0;
    bus.data_in = b;
    @(posedge clk_8f);
    #1;
  endtask

  task automatic apply_stimulus(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic do_reset();
    @(negedge clk_8f);
    reset       = 1'b1;
    bus.data_in = 1'b0;
    @(posedge clk_8f);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_data"}, bus.data_out, 8'h00);
    check_bit({tag, "_valid"}, bus.valid_out, 1'b0);
    check_bit({tag, "_strobe"}, bus.byte_strobe, 1'b0);
    check_bit({tag, "_active"}, bus.active, 1'b0);
  endtask

  initial begin
    bus.data_in = 1'b0;
    do_reset();
    do_reset();
    checking = 1'b1;
    check_reset_values("reset");

    // Clean lock followed by three data bytes
    repeat (3) apply_stimulus(8'hBC);
    check_bit("lock_pending", bus.active, 1'b0);
    apply_stimulus(8'hBC);
    check_bit("lock_active", bus.active, 1'b1);
    check_bit("lock_no_strobe", bus.byte_strobe, 1'b0);
    apply_stimulus(8'hFF);
    check_output("clean_ff", bus.data_out, 8'hFF);
    check_bit("clean_ff_valid", bus.valid_out, 1'b1);
    check_bit("clean_ff_strobe", bus.byte_strobe, 1'b1);
    apply_stimulus(8'hEE);
    check_output("clean_ee", bus.data_out, 8'hEE);
    apply_stimulus(8'h44);
    check_output("clean_44", bus.data_out, 8'h44);

    // Idle comma inside traffic
    apply_stimulus(8'hFF);
    check_bit("idle_ff_valid", bus.valid_out, 1'b1);
    apply_stimulus(8'hBC);
    check_output("idle_hold", bus.data_out, 8'hFF);
    check_bit("idle_valid", bus.valid_out, 1'b0);
    check_bit("idle_strobe", bus.byte_strobe, 1'b1);
    apply_stimulus(8'h44);
    check_output("idle_44", bus.data_out, 8'h44);
    check_bit("idle_44_valid", bus.valid_out, 1'b1);

    // Reset in the middle of a data byte
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    do_reset();
    check_reset_values("midreset");

    // Misaligned start: three stray bits before the commas
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    repeat (4) apply_stimulus(8'hBC);
    check_bit("misalign_active", bus.active, 1'b1);
    apply_stimulus(8'h11);
    check_output("misalign_11", bus.data_out, 8'h11);
    check_bit("misalign_valid", bus.valid_out, 1'b1);

    // Broken sync: a data byte before enough commas
    do_reset();
    repeat (3) apply_stimulus(8'hBC);
    apply_stimulus(8'h4E);
    check_bit("broken_active", bus.active, 1'b0);
    check_bit("broken_strobe", bus.byte_strobe, 1'b0);
    apply_stimulus(8'h00);
    apply_stimulus(8'h00);
    check_bit("broken_still_idle", bus.active, 1'b0);
    check_bit("broken_valid", bus.valid_out, 1'b0);

    // Stream slipped by two inserted bits while ACTIVE
    do_reset();
    repeat (4) apply_stimulus(8'hBC);
    apply_stimulus(8'h55);
    check_output("slip_55", bus.data_out, 8'h55);
    apply_stimulus(8'hBC);
    send_bit(1'b0);
    send_bit(1'b0);
    repeat (4) apply_stimulus(8'hBC);
    apply_stimulus(8'h22);
`ifndef RX_REALIGN_EN
    check_bit("slip_sticky_active", bus.active, 1'b1);
    check_output("slip_misframed", bus.data_out, 8'h08);
    check_bit("slip_misframed_valid", bus.valid_out, 1'b1);
`endif

    repeat (2) send_bit(1'b0);
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_parallel_rx.md
# serial_parallel_rx

Receive-side stage that consumes the 1-bit serial stream produced by the parallel-to-serial transmitter and rebuilds 8-bit words.

- Locks byte alignment on the idle comma (0xBC), which the transmitter sends whenever its `valid_in` is low.
- Declares the link active after a run of aligned commas.
- Delivers data bytes with a valid flag, mapping idle commas to `valid_out=0`.
- Runs entirely in the `clk_8f` domain: one bit per cycle, one byte per 8 cycles.

## Interface
Parameters:
- `COMMA_COUNT`, default 4: consecutive boundary-aligned commas required to enter ACTIVE (range 1–15).

Ports:
- `clk_8f`  in  1  bit clock; the only clock; all logic on its rising edge.
- `reset`  in  1  synchronous reset, active-high.
- `data_in`  in  1  serial bit, MSB of each byte first.
- `data_out`  out  8  last framed byte (data bytes only; holds its value on idle).
- `valid_out`  out  1  high while `data_out` carries a data byte from the current frame.
- `byte_strobe`  out  1  one-cycle pulse at each byte boundary while ACTIVE.
- `active`  out  1  alignment locked; link carrying framed traffic.

## Operation
- Shift register: `sr <= {sr[6:0], data_in}` every cycle; `nxt = {sr[6:0], data_in}` is used for all same-edge decisions.
- Bit counter `bc` (3 bits) wraps 7→0. A boundary occurs when `bc == 7`.
- States:
  - **SEARCH**
    - Checks `nxt == 0xBC` every cycle.
    - On a match: `bc <= 0`, `ccnt <= 1`. Go to SYNC, or directly to ACTIVE if `COMMA_COUNT == 1`.
  - **SYNC** (evaluated only at boundaries)
    - `nxt == 0xBC`: `ccnt++`. When `ccnt` reaches `COMMA_COUNT`, go to ACTIVE.
    - Any other byte: go to SEARCH and clear `ccnt`.
  - **ACTIVE** (at each boundary)
    - `byte_strobe <= 1`.
    - If `nxt == 0xBC`: `valid_out <= 0`, `data_out` unchanged.
    - Otherwise: `data_out <= nxt`, `valid_out <= 1`.
    - ACTIVE is left only through reset, or through realign when `RX_REALIGN_EN` is defined.
- A data byte equal to 0xBC cannot be carried; by protocol it is always idle.
- `active` = (state == ACTIVE), registered.
- Reset values:
  - state SEARCH
  - `sr` = 0
  - `bc` = 0
  - `ccnt` = 0
  - `data_out` = 8'h00
  - `valid_out` = 0
  - `byte_strobe` = 0
  - `active` = 0
- Reset mid-byte or mid-lock discards all partial state. Alignment restarts from SEARCH on the first cycle after reset deasserts.

## Timing
- Last bit (LSB) of a byte is on `data_in` before edge *t*. At edge *t*, `data_out`, `valid_out` and `byte_strobe` update. Latency is 0 cycles past the final bit.
- `valid_out` and `data_out` hold for 8 cycles until the next boundary. `byte_strobe` is high for exactly 1 of those 8.
- Entering ACTIVE occurs at the edge where the `COMMA_COUNT`th comma completes. `active` rises at that edge. The first `byte_strobe` comes 8 cycles later.
- In SEARCH a comma may lock at any bit offset. The counter is forced so that the next boundary falls exactly 8 cycles after the match.

## Configuration
- `RX_REALIGN_EN`
  - **Defined:** in ACTIVE, if the previous framed byte was a comma and `nxt == 0xBC` at a non-boundary cycle:
    - go to SEARCH-equivalent relock: `bc <= 0`, `ccnt <= 1`, state SYNC;
    - drop `active`;
    - force `valid_out <= 0`.
  - **Undefined:** ACTIVE is sticky until reset, and off-boundary commas are ignored.

## Structure
- Shared package `sp_pkg`:
  - `COMMA = 8'hBC`
  - state enum `{SEARCH, SYNC, ACTIVE}`
  - the byte typedef shared with the transmitter.
- One natural sub-module: `comma_detector`. It holds the shift register and the `nxt == COMMA` compare, and outputs `nxt` and a match flag. The FSM, counters and output registers stay in the top module.

## Test plan
- **Clean lock:** after reset, send 0xBC ×4 then 0xFF, 0xEE, 0x44 MSB-first -> `active` rises on the 4th comma's last bit; `data_out` = FF, EE, 44 with `valid_out=1`; `byte_strobe` every 8 cycles.
- **Idle inside traffic:** ACTIVE, send 0xFF, 0xBC, 0x44 -> `valid_out` goes 1, 0, 1; `data_out` holds FF during the idle frame, then 44.
- **Misaligned start:** 3 bits `101`, then 0xBC ×4, then 0x11 -> lock at offset 3; `data_out`=11, `valid_out=1`.
- **Broken sync:** 0xBC ×3 then 0x4E -> returns to SEARCH; `active` stays 0; no `byte_strobe`.
- **Reset mid-operation:** assert `reset` for 1 cycle in the middle of byte 0x44 while ACTIVE -> next cycle all outputs at reset values; relock needs 4 new commas.
- **Realign** (`RX_REALIGN_EN` only): in ACTIVE, send 0xBC then slip the stream by 2 bits followed by 0xBC ×4 -> `active` drops at the off-boundary comma and re-rises after lock; without the macro, `active` stays 1.
